// File: rtl/fft16_frame_ctrl_if.sv
// Stream and datapath signals of the 16-point FFT frame sequencer.
// The controller uses the slave side and the environment uses the master side.
interface fft16_frame_ctrl_if;
  logic         in_valid;
  logic [15:0]  in_data;
  logic         in_ready;
  logic [511:0] fft_in_bus;
  logic         fft_in_valid;
  logic [511:0] fft_out_bus;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_real;
  logic [15:0]  out_imag;
  logic [3:0]   out_idx;
  logic         frame_done;

  modport slave (
    input  in_valid, in_data, fft_out_bus, out_ready,
    output in_ready, fft_in_bus, fft_in_valid, out_valid, out_real, out_imag, out_idx, frame_done
  );

  modport master (
    output in_valid, in_data, fft_out_bus, out_ready,
    input  in_ready, fft_in_bus, fft_in_valid, out_valid, out_real, out_imag, out_idx, frame_done
  );
endinterface

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for the 16-point DIF FFT: serial fill, 512-bit launch,
// capture after DP_LAT cycles, serial drain in natural bin order.
module fft16_frame_ctrl #(
  parameter int DP_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  fft16_frame_ctrl_if.slave io
);
  localparam int LW = (DP_LAT < 1) ? 1 : $clog2(DP_LAT + 1);

  typedef enum logic       {FILL, FULL}        in_st_e;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} out_st_e;

  in_st_e            in_st_q, in_st_d;
  out_st_e           out_st_q, out_st_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic [3:0]        rd_cnt_q, rd_cnt_d;
  logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [15:0][15:0] in_buf_q, in_buf_d;
  logic [15:0][31:0] out_buf_q, out_buf_d;
  logic [511:0]      fft_in_bus_q, fft_in_bus_d;
  logic              launch, launch_nxt, drain, hs;
  logic [31:0]       bin_word;

  function automatic logic [3:0] bitrev4(input logic [3:0] b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  assign launch = (in_st_q == FULL) && (out_st_q == IDLE);
  assign drain  = (out_st_q == DRAIN);
  assign hs     = drain && io.out_ready;

  always_comb begin
    in_st_d  = in_st_q;
    wr_cnt_d = wr_cnt_q;
    in_buf_d = in_buf_q;
    case (in_st_q)
      FILL: if (io.in_valid) begin
        in_buf_d[wr_cnt_q] = io.in_data;
        wr_cnt_d           = wr_cnt_q + 4'd1;
        if (wr_cnt_q == 4'd15) in_st_d = FULL;
      end
      FULL:    if (launch) in_st_d = FILL;
      default: in_st_d = FILL;
    endcase
  end

  always_comb begin
    out_st_d  = out_st_q;
    lat_cnt_d = lat_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    out_buf_d = out_buf_q;
    case (out_st_q)
      IDLE: if (launch) begin
        lat_cnt_d = LW'(DP_LAT);
        // A combinational datapath already holds the result during the launch cycle.
        if (DP_LAT == 0) begin
          out_buf_d = io.fft_out_bus;
          out_st_d  = DRAIN;
        end else begin
          out_st_d  = WAIT;
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - LW'(1);
        if (lat_cnt_q == LW'(1)) begin
          out_buf_d = io.fft_out_bus;
          out_st_d  = DRAIN;
        end
      end
      DRAIN: if (io.out_ready) begin
        rd_cnt_d = rd_cnt_q + 4'd1;
        if (rd_cnt_q == 4'd15) out_st_d = IDLE;
      end
      default: out_st_d = IDLE;
    endcase
  end

  // Load the launch copy one edge early so it is on the bus during the launch cycle.
  assign launch_nxt = (in_st_d == FULL) && (out_st_d == IDLE);

  always_comb begin
    fft_in_bus_d = fft_in_bus_q;
    if (launch_nxt) begin
      for (int k = 0; k < 16; k++) fft_in_bus_d[32*k +: 32] = {in_buf_d[k], 16'h0000};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_st_q      <= FILL;
      out_st_q     <= IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      lat_cnt_q    <= '0;
      fft_in_bus_q <= '0;
    end else begin
      in_st_q      <= in_st_d;
      out_st_q     <= out_st_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      fft_in_bus_q <= fft_in_bus_d;
    end
  end

  // Frame storage needs no reset; every read of it is gated by FSM state.
  always_ff @(posedge clk) begin
    in_buf_q  <= in_buf_d;
    out_buf_q <= out_buf_d;
  end

  assign bin_word        = drain ? out_buf_q[bitrev4(rd_cnt_q)] : 32'h0;
  assign io.in_ready     = (in_st_q == FILL);
  assign io.fft_in_valid = launch;
  assign io.fft_in_bus   = fft_in_bus_q;
  assign io.out_valid    = drain;
  assign io.out_real     = bin_word[31:16];
  assign io.out_imag     = bin_word[15:0];
  assign io.out_idx      = drain ? rd_cnt_q : 4'd0;
  assign io.frame_done   = hs && (rd_cnt_q == 4'd15);
endmodule
